// File: rtl/inst_fetch.sv
// inst_fetch: program counter plus a single-outstanding instruction fetch.
// A fetch latches the current PC as the request address, holds mem_req until
// memory signals ready, captures the word into IR and pulses en1 for one cycle.
// The PC updates independently of the fetch whenever en_pc_pulse is high.
module inst_fetch #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_fetch_pulse,
    input  logic            en_pc_pulse,
    input  logic [1:0]      pc_ctrl,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [IW-1:0]   mem_rdata,
    output logic            en1,
    output logic            busy,
    output logic            err_overrun,
    output logic [PC_W-1:0] pc,
    output logic [IW-1:0]   ir,
    output logic [3:0]      opcode,
    output logic [1:0]      rd,
    output logic [1:0]      rs1,
    output logic [1:0]      rs2,
    output logic [7:0]      imm
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state_p0;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] addr_p0;
    logic [IW-1:0]   ir_p0;
    logic            ovr_p0;
    logic            fetch_go;
    logic            capture;

    // Next PC: hold, increment, relative branch by signed imm, or clear.
    // All results wrap modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_next(
        input logic [PC_W-1:0] cur,
        input logic [1:0]      sel,
        input logic [7:0]      imm8
    );
        logic signed [7:0]      imm_s;
        logic signed [PC_W-1:0] off;
        imm_s = imm8;
        off   = PC_W'(imm_s);
        case (sel)
            2'b00:   pc_next = cur;
            2'b01:   pc_next = cur + PC_W'(1);
            2'b10:   pc_next = cur + $unsigned(off);
            default: pc_next = '0;
        endcase
    endfunction

    // A fetch is only started from IDLE; memory data is only taken while requesting.
    assign fetch_go = en_fetch_pulse && (state_p0 == IDLE);
    assign capture  = mem_req && mem_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_p0 <= IDLE;
        else        state_p0 <= state_nxt;
    end

    // Next-state and state-decoded outputs (all derived from the state register).
    always_comb begin
        state_nxt = state_p0;
        mem_req   = 1'b0;
        en1       = 1'b0;
        busy      = 1'b0;
        case (state_p0)
            IDLE: begin
                if (en_fetch_pulse) state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ready) state_nxt = DONE;
            end
            DONE: begin
                en1       = 1'b1;
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Program counter; uses the pre-capture IR for the branch offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pc_p0 <= '0;
        else if (en_pc_pulse) pc_p0 <= pc_next(pc_p0, pc_ctrl, ir_p0[7:0]);
    end

    // Request address latched from the old PC at fetch start; held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        addr_p0 <= '0;
        else if (fetch_go) addr_p0 <= pc_p0;
    end

    // Instruction register captured on the accepting handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ir_p0 <= '0;
        else if (capture) ir_p0 <= mem_rdata;
    end

    // Sticky overrun: a fetch request arrived while one was already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    ovr_p0 <= 1'b0;
        else if (en_fetch_pulse && state_p0 != IDLE)   ovr_p0 <= 1'b1;
    end

    assign mem_addr    = addr_p0;
    assign pc          = pc_p0;
    assign ir          = ir_p0;
    assign err_overrun = ovr_p0;
    assign opcode      = ir_p0[15:12];
    assign rd          = ir_p0[11:10];
    assign rs1         = ir_p0[9:8];
    assign rs2         = ir_p0[7:6];
    assign imm         = ir_p0[7:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a simple combinational memory model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_fetch_pulse = 1'b0;
    logic        en_pc_pulse = 1'b0;
    logic [1:0]  pc_ctrl = 2'b00;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata;
    logic        en1;
    logic        busy;
    logic        err_overrun;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [7:0]  imm;

    logic [15:0] mem [0:255];
    int tests = 0;
    int fails = 0;

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    inst_fetch #(.PC_W(8), .IW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_fetch_pulse(en_fetch_pulse), .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .en1(en1), .busy(busy), .err_overrun(err_overrun), .pc(pc), .ir(ir),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus helper: one zero-wait fetch, optionally with a PC strobe, returning in IDLE.
    task automatic run_fetch(input logic pc_en, input logic [1:0] ctrl);
        bit seen;
        seen = 1'b0;
        mem_ready = 1'b1;
        en_fetch_pulse = 1'b1;
        en_pc_pulse = pc_en;
        pc_ctrl = ctrl;
        tick();
        en_fetch_pulse = 1'b0;
        en_pc_pulse = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (en1 === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL run_fetch_timeout: en1 not seen, required 1");
        end
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({mem_req, en1, busy, err_overrun} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000", {mem_req, en1, busy, err_overrun});
        end
        tests++;
        if ({pc, mem_addr, ir} !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: pc=%h addr=%h ir=%h required 0", pc, mem_addr, ir);
        end
        tests++;
        if ({opcode, rd, rs1, rs2, imm} !== 18'h0) begin
            fails++;
            $display("FAIL reset_fields: got %h required 0", {opcode, rd, rs1, rs2, imm});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait;
        mem[0] = 16'h1A40;
        mem_ready = 1'b1;
        en_fetch_pulse = 1'b1;
        en_pc_pulse = 1'b1;
        pc_ctrl = 2'b01;
        tick();
        en_fetch_pulse = 1'b0;
        en_pc_pulse = 1'b0;
        tests++;
        if (mem_addr !== 8'h00 || pc !== 8'h01 || mem_req !== 1'b1 || en1 !== 1'b0) begin
            fails++;
            $display("FAIL zw_req: addr=%h pc=%h req=%b en1=%b required 00 01 1 0", mem_addr, pc, mem_req, en1);
        end
        tick();
        tests++;
        if (en1 !== 1'b1 || ir !== 16'h1A40 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL zw_done: en1=%b ir=%h req=%b required 1 1a40 0", en1, ir, mem_req);
        end
        tests++;
        if (opcode !== 4'd1 || rd !== 2'd2 || rs1 !== 2'd2 || rs2 !== 2'd1 || imm !== 8'h40) begin
            fails++;
            $display("FAIL zw_fields: op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h required 1 2 2 1 40", opcode, rd, rs1, rs2, imm);
        end
        tick();
        tests++;
        if (en1 !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zw_idle: en1=%b busy=%b required 0 0", en1, busy);
        end
    endtask

    task automatic test_wait_states;
        int pulses;
        pulses = 0;
        mem[1] = 16'h2B7F;
        mem_ready = 1'b0;
        en_fetch_pulse = 1'b1;
        tick();
        en_fetch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== 8'h01 || en1 !== 1'b0) begin
                fails++;
                $display("FAIL ws_hold%0d: req=%b addr=%h en1=%b required 1 01 0", i, mem_req, mem_addr, en1);
            end
            tick();
        end
        tests++;
        if (en1 !== 1'b1 || ir !== 16'h2B7F) begin
            fails++;
            $display("FAIL ws_done: en1=%b ir=%h required 1 2b7f", en1, ir);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (en1 === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL ws_single: extra en1 pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_pc_arith;
        en_pc_pulse = 1'b1; pc_ctrl = 2'b11; tick(); en_pc_pulse = 1'b0;
        tests++;
        if (pc !== 8'h00) begin fails++; $display("FAIL pc_clear: pc=%h required 00", pc); end
        mem[0] = 16'h30FF;
        run_fetch(1'b0, 2'b00);
        tests++;
        if (ir !== 16'h30FF || pc !== 8'h00) begin
            fails++;
            $display("FAIL pc_ld_ff: ir=%h pc=%h required 30ff 00", ir, pc);
        end
        // memory word under the held address changes while IDLE with ready high
        mem[0] = 16'hBEEF;
        mem_ready = 1'b1;
        tick(); tick();
        tests++;
        if (ir !== 16'h30FF) begin fails++; $display("FAIL ready_idle: ir=%h required 30ff", ir); end
        en_pc_pulse = 1'b1; pc_ctrl = 2'b10; tick(); en_pc_pulse = 1'b0;
        tests++;
        if (pc !== 8'hFF) begin fails++; $display("FAIL pc_neg1: pc=%h required ff", pc); end
        en_pc_pulse = 1'b1; pc_ctrl = 2'b01; tick(); en_pc_pulse = 1'b0;
        tests++;
        if (pc !== 8'h00) begin fails++; $display("FAIL pc_wrap: pc=%h required 00", pc); end
        mem[0] = 16'h0005;
        run_fetch(1'b0, 2'b00);
        en_pc_pulse = 1'b1; pc_ctrl = 2'b10; tick(); en_pc_pulse = 1'b0;
        tests++;
        if (pc !== 8'h05) begin fails++; $display("FAIL pc_plus5: pc=%h required 05", pc); end
        mem[5] = 16'h00FE;
        run_fetch(1'b0, 2'b00);
        en_pc_pulse = 1'b1; pc_ctrl = 2'b10; tick(); en_pc_pulse = 1'b0;
        tests++;
        if (pc !== 8'h03) begin fails++; $display("FAIL pc_minus2: pc=%h required 03", pc); end
        en_pc_pulse = 1'b1; pc_ctrl = 2'b00; tick(); en_pc_pulse = 1'b0;
        tests++;
        if (pc !== 8'h03) begin fails++; $display("FAIL pc_hold: pc=%h required 03", pc); end
        pc_ctrl = 2'b01; tick(); tick();
        tests++;
        if (pc !== 8'h03) begin fails++; $display("FAIL pc_nostrobe: pc=%h required 03", pc); end
        pc_ctrl = 2'b00;
    endtask

    task automatic test_overrun;
        mem[3] = 16'hC3A5;
        mem_ready = 1'b0;
        en_fetch_pulse = 1'b1;
        tick();
        tick();
        en_fetch_pulse = 1'b0;
        tests++;
        if (err_overrun !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 8'h03) begin
            fails++;
            $display("FAIL ovr_flag: ovr=%b req=%b addr=%h required 1 1 03", err_overrun, mem_req, mem_addr);
        end
        mem_ready = 1'b1;
        tick();
        tests++;
        if (en1 !== 1'b1 || ir !== 16'hC3A5) begin
            fails++;
            $display("FAIL ovr_done: en1=%b ir=%h required 1 c3a5", en1, ir);
        end
        tick();
        tick();
        tests++;
        if (err_overrun !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL ovr_sticky: ovr=%b busy=%b req=%b required 1 0 0", err_overrun, busy, mem_req);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        mem_ready = 1'b0;
        en_fetch_pulse = 1'b1;
        tick();
        en_fetch_pulse = 1'b0;
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL rm_inreq: req=%b required 1", mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || en1 !== 1'b0 || err_overrun !== 1'b0) begin
            fails++;
            $display("FAIL rm_async: req=%b busy=%b en1=%b ovr=%b required 0 0 0 0", mem_req, busy, en1, err_overrun);
        end
        tests++;
        if ({pc, ir, mem_addr, opcode} !== 36'h0) begin
            fails++;
            $display("FAIL rm_data: pc=%h ir=%h addr=%h op=%h required 0", pc, ir, mem_addr, opcode);
        end
        mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (en1 === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL rm_noen1: pulses=%0d required 0", pulses); end
        mem[0] = 16'h5E81;
        en_fetch_pulse = 1'b1;
        tick();
        en_fetch_pulse = 1'b0;
        tests++;
        if (mem_addr !== 8'h00 || mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rm_refetch: addr=%h req=%b required 00 1", mem_addr, mem_req);
        end
        tick();
        tests++;
        if (en1 !== 1'b1 || ir !== 16'h5E81) begin
            fails++;
            $display("FAIL rm_refetch_ir: en1=%b ir=%h required 1 5e81", en1, ir);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [0:3];
        int pulses;
        words[0] = 16'h4C12; words[1] = 16'h7781; words[2] = 16'h93C0; words[3] = 16'hF0FF;
        pulses = 0;
        for (int i = 0; i < 4; i++) mem[i] = words[i];
        en_pc_pulse = 1'b1; pc_ctrl = 2'b11; tick(); en_pc_pulse = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en_fetch_pulse = 1'b1;
            en_pc_pulse = 1'b1;
            pc_ctrl = 2'b01;
            tick();
            en_fetch_pulse = 1'b0;
            en_pc_pulse = 1'b0;
            tests++;
            if (mem_addr !== 8'(i) || pc !== 8'(i + 1)) begin
                fails++;
                $display("FAIL b2b_addr%0d: addr=%h pc=%h required %h %h", i, mem_addr, pc, 8'(i), 8'(i + 1));
            end
            tick();
            if (en1 === 1'b1) pulses++;
            tests++;
            if (ir !== words[i]) begin
                fails++;
                $display("FAIL b2b_ir%0d: ir=%h required %h", i, ir, words[i]);
            end
            tick();
            tests++;
            if (en1 !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL b2b_idle%0d: en1=%b busy=%b required 0 0", i, en1, busy);
            end
        end
        tests++;
        if (pulses !== 4) begin fails++; $display("FAIL b2b_pulses: got %0d required 4", pulses); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_pc_arith();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the multi-cycle CPU. It holds the program counter and fetches one instruction word from instruction memory through a ready-based request handshake. It latches the word into the instruction register and decodes the opcode/register fields. It is driven by the control FSM's `en_fetch_pulse`, `en_pc_pulse` and `pc_ctrl`, and returns `en1` (fetch done) plus `opcode`/`rd`, which the FSM consumes.

## Interface
- `PC_W`, 8, program counter and memory address width.
- `IW`, 16, instruction width. Fixed at 16 by the field layout below.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_fetch_pulse`  in  1  one-cycle request to start a fetch at the current PC.
- `en_pc_pulse`  in  1  one-cycle PC update strobe.
- `pc_ctrl`  in  2  PC update select: 00 hold, 01 PC+1, 10 PC+sext(imm), 11 PC=0.
- `mem_req`  out  1  memory read request, held until accepted.
- `mem_addr`  out  PC_W  read address, stable while `mem_req` is high.
- `mem_ready`  in  1  memory accepts the request and presents `mem_rdata` this cycle.
- `mem_rdata`  in  IW  instruction word.
- `en1`  out  1  one-cycle pulse: IR updated and fields valid.
- `busy`  out  1  fetch in progress.
- `err_overrun`  out  1  sticky flag: a fetch request arrived while busy.
- `pc`  out  PC_W  program counter.
- `ir`  out  IW  instruction register.
- `opcode`  out  4  `ir[15:12]`.
- `rd`  out  2  `ir[11:10]`.
- `rs1`  out  2  `ir[9:8]`.
- `rs2`  out  2  `ir[7:6]`.
- `imm`  out  8  `ir[7:0]`.

## Operation
- States: IDLE, REQ, DONE.
  - IDLE → REQ on `en_fetch_pulse`. At the same edge, `mem_addr` ← current `pc`, the pre-update value.
  - REQ → DONE on `mem_req && mem_ready`. At that edge, `ir` ← `mem_rdata`.
  - DONE → IDLE unconditionally.
- Outputs by state:
  - `mem_req` = 1 only in REQ.
  - `en1` = 1 only in DONE.
  - `busy` = 1 in REQ and DONE.
- PC update occurs on any edge where `en_pc_pulse` = 1, independent of fetch state:
  - 00: hold.
  - 01: `pc` + 1.
  - 10: `pc` + sign-extended `imm`, using the current `ir`.
  - 11: 0.
- Arithmetic is modulo 2^PC_W. `pc` = 2^PC_W−1 with 01 wraps to 0. Negative offsets wrap the same way.
- Simultaneous `en_fetch_pulse` and `en_pc_pulse` (the normal IF entry): the fetch uses the old PC and `pc` takes the new value at the same edge. The fetched address is never the incremented one.
- `en_fetch_pulse` in REQ or DONE: ignored, no restart, and `err_overrun` ← 1. `err_overrun` clears only on reset.
- `mem_ready` outside REQ is ignored and `ir` is unchanged.
- `opcode`/`rd`/`rs1`/`rs2`/`imm` are combinational slices of `ir`. They are stable outside the capture edge.

## Timing
- Reset values:
  - State IDLE.
  - `pc` = 0, `ir` = 0, `mem_addr` = 0.
  - `mem_req` = 0, `en1` = 0, `busy` = 0, `err_overrun` = 0.
  - All decoded fields = 0.
- Reset asserted mid-fetch: state returns to IDLE immediately and `mem_req` drops asynchronously. `ir` and `pc` clear. No `en1` is produced for the aborted fetch.
- Latency from the edge sampling `en_fetch_pulse` to `en1` high is 2 + W cycles, where W is the number of REQ cycles with `mem_ready` = 0.
  - With `mem_ready` tied high: pulse sampled at edge k, `mem_req` high in cycle k+1, IR captured at edge k+1, `en1` high in cycle k+2 only.
- `mem_addr` and `mem_req` come from registers (no combinational path from inputs). `mem_addr` holds its value after the request completes.
- Back-to-back fetches: a new `en_fetch_pulse` is accepted in the same cycle `en1` is low and the state is IDLE. The minimum request spacing is 3 cycles.

## Test plan
- Reset then fetch with zero wait: mem[0] = 16'h1A40, pulse both strobes with `pc_ctrl` = 01 → `mem_addr` = 0, `pc` = 1, `en1` 2 cycles later, `ir` = 16'h1A40, `opcode` = 1, `rd` = 2, `rs1` = 2, `rs2` = 1.
- Wait states: hold `mem_ready` low for 3 REQ cycles → `mem_req`/`mem_addr` stable throughout, `en1` after exactly 5 cycles, single pulse.
- PC arithmetic:
  - `pc` = 8'hFF with 01 → 8'h00.
  - `ir` imm = 8'hFE, `pc` = 5 with 10 → 3.
  - `pc_ctrl` = 11 → 0.
  - `pc_ctrl` = 00 → unchanged.
- Overrun: second `en_fetch_pulse` in REQ → fetch completes normally to the original address, `err_overrun` = 1 and remains set until `rst_n` low.
- Reset mid-operation: drop `rst_n` in REQ → `mem_req` = 0 immediately, all outputs at reset values, no `en1`. The next fetch after release reads address 0.
- Sequence of four fetches with 01 increments → addresses 0, 1, 2, 3 requested in order, four `en1` pulses, IR matches each memory word.
